// File: rtl/eeprom_i2c_slave_if.sv
// Two-wire EEPROM bus bundle: scl/sda as seen on the wired-AND bus, the responder's
// pull-down enable for sda, and responder status (busy, write strobe, address pointer).
interface eeprom_i2c_slave_if #(
   parameter int ADDR_W = 11
);
   logic              scl;
   logic              sda;
   logic              sda_pull;
   logic              busy;
   logic              wr_pulse;
   logic [ADDR_W-1:0] ptr;

   modport master (output scl, sda, input sda_pull, busy, wr_pulse, ptr);
   modport slave  (input scl, sda, output sda_pull, busy, wr_pulse, ptr);
endinterface

// File: rtl/eeprom_i2c_slave.sv
// Serial EEPROM responder (2K x 8) for the two-wire bus, oversampled on clk.
// Optional write protect input wp is enabled by defining EEPROM_WP_EN.
//
// state     | meaning
// IDLE      | waiting for START (also parks here after a foreign device code)
// CTRL      | shifting in control byte
// CTRL_ACK  | pulling sda low for control ACK
// ADDR      | shifting in address low byte
// ADDR_ACK  | pulling sda low for address ACK
// WDATA     | shifting in write data
// WDATA_ACK | pulling sda low for data ACK
// RDATA     | shifting read data out, MSB first
// RDATA_ACK | sampling master ACK/NACK
module eeprom_i2c_slave #(
   parameter logic [3:0] DEV_CODE = 4'b1010,
   parameter int         ADDR_W   = 11,
   parameter logic [7:0] MEM_INIT = 8'hFF
) (
   input logic clk,
   input logic rst,
`ifdef EEPROM_WP_EN
   input logic wp,
`endif
   eeprom_i2c_slave_if.slave bus
);
   typedef enum logic [3:0] {
      IDLE, CTRL, CTRL_ACK, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
   } state_t;

   state_t     state;
   logic       scl_s1, scl_s2, scl_prev;
   logic       sda_s1, sda_s2, sda_prev;
   logic [3:0] bit_cnt;
   logic [7:0] shreg;
   logic [7:0] mem [0:(1<<ADDR_W)-1] = '{default: MEM_INIT};

   logic       scl_rise, scl_fall, start_det, stop_det, byte_done, mem_we, wp_on;
   logic [7:0] rx_byte, rd_byte;

   assign scl_rise  = scl_s2 & ~scl_prev;
   assign scl_fall  = ~scl_s2 & scl_prev;
   assign start_det = scl_s2 & scl_prev & sda_prev & ~sda_s2;
   assign stop_det  = scl_s2 & scl_prev & ~sda_prev & sda_s2;
   assign rx_byte   = {shreg[6:0], sda_s2};
   assign byte_done = scl_rise && (bit_cnt == 4'd7);
   assign rd_byte   = mem[bus.ptr];
`ifdef EEPROM_WP_EN
   assign wp_on = wp;
`else
   assign wp_on = 1'b0;
`endif
   assign mem_we = (state == WDATA) && byte_done && !start_det && !stop_det && !wp_on;

   // Idle bus is high, so reset the synchronizers high to avoid a phantom edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         {scl_s1, scl_s2, scl_prev} <= 3'b111;
         {sda_s1, sda_s2, sda_prev} <= 3'b111;
      end else begin
         {scl_s1, scl_s2, scl_prev} <= {bus.scl, scl_s1, scl_s2};
         {sda_s1, sda_s2, sda_prev} <= {bus.sda, sda_s1, sda_s2};
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[bus.ptr] <= rx_byte;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         bit_cnt      <= 4'd0;
         shreg        <= 8'd0;
         bus.sda_pull <= 1'b0;
         bus.busy     <= 1'b0;
         bus.wr_pulse <= 1'b0;
         bus.ptr      <= '0;
      end else begin
         bus.wr_pulse <= mem_we;
         if (start_det) begin
            state        <= CTRL;
            bit_cnt      <= 4'd0;
            bus.sda_pull <= 1'b0;
            bus.busy     <= 1'b1;
         end else if (stop_det) begin
            state        <= IDLE;
            bus.sda_pull <= 1'b0;
            bus.busy     <= 1'b0;
         end else begin
            case (state)
               CTRL, ADDR, WDATA: if (scl_rise) begin
                  shreg   <= rx_byte;
                  bit_cnt <= bit_cnt + 4'd1;
                  if (byte_done) begin
                     bit_cnt <= 4'd0;
                     case (state)
                        CTRL: if (rx_byte[7:4] != DEV_CODE) begin
                           state <= IDLE;
                        end else begin
                           state <= CTRL_ACK;
                           if (!rx_byte[0]) bus.ptr[ADDR_W-1:8] <= rx_byte[ADDR_W-8:1];
                        end
                        ADDR: begin
                           bus.ptr[7:0] <= rx_byte;
                           state        <= ADDR_ACK;
                        end
                        default: if (wp_on) begin
                           state <= IDLE;
                        end else begin
                           bus.ptr <= bus.ptr + 1'b1;
                           state   <= WDATA_ACK;
                        end
                     endcase
                  end
               end
               // First fall after the byte asserts ACK, the next one releases it.
               CTRL_ACK, ADDR_ACK, WDATA_ACK: if (scl_fall) begin
                  if (!bus.sda_pull) begin
                     bus.sda_pull <= 1'b1;
                  end else begin
                     bus.sda_pull <= 1'b0;
                     bit_cnt      <= 4'd0;
                     if (state == CTRL_ACK && shreg[0]) begin
                        shreg        <= rd_byte;
                        bus.sda_pull <= ~rd_byte[7];
                        state        <= RDATA;
                     end else if (state == CTRL_ACK) begin
                        state <= ADDR;
                     end else begin
                        state <= WDATA;
                     end
                  end
               end
               // bit_cnt == 8 marks a byte loaded after master ACK, bit7 not yet driven.
               RDATA: if (scl_fall) begin
                  if (bit_cnt == 4'd8) begin
                     bus.sda_pull <= ~shreg[7];
                     bit_cnt      <= 4'd0;
                  end else if (bit_cnt == 4'd7) begin
                     bus.sda_pull <= 1'b0;
                     bus.ptr      <= bus.ptr + 1'b1;
                     state        <= RDATA_ACK;
                  end else begin
                     shreg        <= {shreg[6:0], 1'b0};
                     bus.sda_pull <= ~shreg[6];
                     bit_cnt      <= bit_cnt + 4'd1;
                  end
               end
               RDATA_ACK: if (scl_rise) begin
                  if (!sda_s2) begin
                     shreg   <= rd_byte;
                     bit_cnt <= 4'd8;
                     state   <= RDATA;
                  end else begin
                     state <= IDLE;
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_eeprom_i2c_slave.sv
// Bench for eeprom_i2c_slave: bit-banged bus master, scoreboard of expected ACKs and
// read bytes, a table of write/read-back vectors, and hand sequences for corner cases.
module tb_eeprom_i2c_slave;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sda_m = 1'b1;
`ifdef EEPROM_WP_EN
   logic wp = 1'b0;
`endif
   int   n_cmp = 0;
   int   n_err = 0;
   int   wr_cnt = 0;

   eeprom_i2c_slave_if #(.ADDR_W(11)) bus ();

   eeprom_i2c_slave #(.DEV_CODE(4'b1010), .ADDR_W(11), .MEM_INIT(8'hFF)) dut (
      .clk(clk),
      .rst(rst),
`ifdef EEPROM_WP_EN
      .wp(wp),
`endif
      .bus(bus)
   );

   always #5 clk = ~clk;
   assign bus.sda = sda_m & ~bus.sda_pull;

   always @(posedge clk) if (bus.wr_pulse === 1'b1) wr_cnt++;

   typedef struct { string name; logic [31:0] val; } sb_t;
   sb_t sb_q[$];

   typedef struct { logic [10:0] addr; logic [7:0] data; } vec_t;
   vec_t vecs [4];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic sb_push(input string nm, input logic [31:0] v);
      sb_t e;
      e.name = nm;
      e.val  = v;
      sb_q.push_back(e);
   endtask

   task automatic sb_pop_check(input logic [31:0] act);
      sb_t e;
      if (sb_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL scoreboard_empty: got %0h expected queued entry", act);
      end else begin
         e = sb_q.pop_front();
         check(e.name, act, e.val);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clock_bit(input logic b, output logic r);
      bus.scl = 1'b0; tick(4);
      sda_m   = b;    tick(4);
      bus.scl = 1'b1; tick(7);
      r = bus.sda;    tick(1);
   endtask

   task automatic start_c;
      bus.scl = 1'b0; tick(4);
      sda_m   = 1'b1; tick(4);
      bus.scl = 1'b1; tick(8);
      sda_m   = 1'b0; tick(8);
   endtask

   task automatic stop_c;
      bus.scl = 1'b0; tick(4);
      sda_m   = 1'b0; tick(4);
      bus.scl = 1'b1; tick(8);
      sda_m   = 1'b1; tick(8);
   endtask

   task automatic send_byte(input string nm, input logic [7:0] b, input logic exp_ack);
      logic r;
      sb_push(nm, {31'd0, exp_ack});
      for (int i = 7; i >= 0; i--) clock_bit(b[i], r);
      clock_bit(1'b1, r);
      sb_pop_check({31'd0, r});
   endtask

   task automatic recv_byte(input string nm, input logic [7:0] exp, input logic mack);
      logic       r;
      logic [7:0] d;
      sb_push(nm, {24'd0, exp});
      for (int i = 7; i >= 0; i--) begin
         clock_bit(1'b1, r);
         d[i] = r;
      end
      clock_bit(mack, r);
      sb_pop_check({24'd0, d});
   endtask

   task automatic write_byte(input logic [10:0] a, input logic [7:0] d);
      start_c;
      send_byte("wr_ctrl_ack", {4'b1010, a[10:8], 1'b0}, 1'b0);
      send_byte("wr_addr_ack", a[7:0], 1'b0);
      send_byte("wr_data_ack", d, 1'b0);
      stop_c;
   endtask

   task automatic read_byte(input logic [10:0] a, input logic [7:0] exp);
      start_c;
      send_byte("rd_ctrl_ack", {4'b1010, a[10:8], 1'b0}, 1'b0);
      send_byte("rd_addr_ack", a[7:0], 1'b0);
      start_c;
      send_byte("rd_rctrl_ack", 8'hA1, 1'b0);
      recv_byte("rd_data", exp, 1'b1);
      stop_c;
   endtask

   initial begin
      int   w0;
      logic r;
      vecs[0] = '{addr: 11'h040, data: 8'hA5};
      vecs[1] = '{addr: 11'h2C7, data: 8'h3C};
      vecs[2] = '{addr: 11'h501, data: 8'h00};
      vecs[3] = '{addr: 11'h6FE, data: 8'hC3};

      bus.scl = 1'b1;
      tick(5);
      check("rst_busy", {31'd0, bus.busy}, 0);
      check("rst_wr_pulse", {31'd0, bus.wr_pulse}, 0);
      check("rst_ptr", {21'd0, bus.ptr}, 0);
      check("rst_sda_pull", {31'd0, bus.sda_pull}, 0);
      rst = 1'b0;
      tick(5);

      // byte write with BUSY timing around STOP
      w0 = wr_cnt;
      start_c;
      check("busy_after_start", {31'd0, bus.busy}, 1);
      send_byte("bw_ctrl_ack", 8'hA2, 1'b0);
      send_byte("bw_addr_ack", 8'h23, 1'b0);
      send_byte("bw_data_ack", 8'h5A, 1'b0);
      bus.scl = 1'b0; tick(4);
      sda_m   = 1'b0; tick(4);
      bus.scl = 1'b1; tick(8);
      sda_m   = 1'b1; tick(2);
      check("busy_2clk_after_stop", {31'd0, bus.busy}, 1);
      tick(1);
      check("busy_3clk_after_stop", {31'd0, bus.busy}, 0);
      tick(5);
      check("bw_wr_pulses", wr_cnt - w0, 1);
      check("bw_ptr", {21'd0, bus.ptr}, 32'h124);

      // random read of the byte just written
      read_byte(11'h123, 8'h5A);
      check("rr_sda_released", {31'd0, bus.sda_pull}, 0);
      check("rr_busy", {31'd0, bus.busy}, 0);
      check("rr_ptr", {21'd0, bus.ptr}, 32'h124);

      // foreign device code is ignored until the next START
      w0 = wr_cnt;
      start_c;
      send_byte("bad_ctrl_nack", 8'h92, 1'b1);
      send_byte("bad_addr_ignored", 8'h23, 1'b1);
      send_byte("bad_data_ignored", 8'h44, 1'b1);
      stop_c;
      check("bad_wr_pulses", wr_cnt - w0, 0);
      start_c;
      send_byte("good_ctrl_ack", 8'hA0, 1'b0);
      send_byte("good_addr_ack", 8'h05, 1'b0);
      stop_c;
      check("good_ptr", {21'd0, bus.ptr}, 32'h005);
      read_byte(11'h123, 8'h5A);

      // table-driven write then read-back
      for (int i = 0; i < 4; i++) begin
         w0 = wr_cnt;
         write_byte(vecs[i].addr, vecs[i].data);
         check("vec_wr_pulses", wr_cnt - w0, 1);
         check("vec_wr_ptr", {21'd0, bus.ptr}, {21'd0, 11'(vecs[i].addr + 11'd1)});
      end
      for (int i = 0; i < 4; i++) begin
         read_byte(vecs[i].addr, vecs[i].data);
         check("vec_rd_ptr", {21'd0, bus.ptr}, {21'd0, 11'(vecs[i].addr + 11'd1)});
      end

      // pointer wrap on sequential write and sequential read
      w0 = wr_cnt;
      start_c;
      send_byte("wrap_ctrl_ack", 8'hAE, 1'b0);
      send_byte("wrap_addr_ack", 8'hFF, 1'b0);
      send_byte("wrap_d0_ack", 8'h11, 1'b0);
      send_byte("wrap_d1_ack", 8'h22, 1'b0);
      stop_c;
      check("wrap_wr_pulses", wr_cnt - w0, 2);
      check("wrap_ptr", {21'd0, bus.ptr}, 32'h001);
      start_c;
      send_byte("seq_ctrl_ack", 8'hAE, 1'b0);
      send_byte("seq_addr_ack", 8'hFF, 1'b0);
      start_c;
      send_byte("seq_rctrl_ack", 8'hA1, 1'b0);
      recv_byte("seq_rd0", 8'h11, 1'b0);
      recv_byte("seq_rd1", 8'h22, 1'b1);
      stop_c;
      check("seq_ptr", {21'd0, bus.ptr}, 32'h001);

      // reset while the responder is driving bit3 (0) of 0xA5
      start_c;
      send_byte("mr_ctrl_ack", 8'hA0, 1'b0);
      send_byte("mr_addr_ack", 8'h40, 1'b0);
      start_c;
      send_byte("mr_rctrl_ack", 8'hA1, 1'b0);
      for (int i = 0; i < 4; i++) clock_bit(1'b1, r);
      bus.scl = 1'b0;
      tick(5);
      check("mr_driving_bit3", {31'd0, bus.sda_pull}, 1);
      rst = 1'b1;
      #1;
      check("mr_sda_released", {31'd0, bus.sda_pull}, 0);
      check("mr_busy", {31'd0, bus.busy}, 0);
      check("mr_ptr", {21'd0, bus.ptr}, 0);
      bus.scl = 1'b1;
      sda_m   = 1'b1;
      tick(4);
      rst = 1'b0;
      tick(4);
      w0 = wr_cnt;
      write_byte(11'h007, 8'h99);
      check("mr_wr_pulses", wr_cnt - w0, 1);
      read_byte(11'h007, 8'h99);

`ifdef EEPROM_WP_EN
      w0 = wr_cnt;
      wp = 1'b1;
      start_c;
      send_byte("wp_ctrl_ack", 8'hA0, 1'b0);
      send_byte("wp_addr_ack", 8'h10, 1'b0);
      send_byte("wp_data_nack", 8'h77, 1'b1);
      stop_c;
      check("wp_wr_pulses", wr_cnt - w0, 0);
      check("wp_ptr", {21'd0, bus.ptr}, 32'h010);
      wp = 1'b0;
      read_byte(11'h010, 8'hFF);
      write_byte(11'h010, 8'h77);
      check("wp_off_wr_pulses", wr_cnt - w0, 1);
      read_byte(11'h010, 8'h77);
`endif

      if (sb_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
